// File: rtl/audio_sample_streamer.sv
// Audio sample streamer: fetches Q1.14 samples from a word-indexed sample ROM with a
// 1-cycle registered read, paces them at one per SAMPLE_DIV clocks and presents them on a
// valid/ready stream. Optional feature macro: AUDIO_STREAM_LOOP_EN (endless clip looping).
module audio_sample_streamer #(
    parameter int unsigned NUM_SAMPLES = 32000,
    parameter int unsigned SAMPLE_DIV  = 1042
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    output logic [31:0] rom_addr,
    input  logic [15:0] rom_rd,
    output logic [15:0] sample_data,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        busy,
    output logic        done,
    output logic        underrun
);

    localparam int unsigned IW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam int unsigned DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(NUM_SAMPLES - 1);
    localparam logic [DW-1:0] LastDiv = DW'(SAMPLE_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StCapture,
        StPresent,
        StPace
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DW-1:0] div_q, div_d;
    logic          tick_pend_q, tick_pend_d;
    logic [15:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          underrun_q, underrun_d;
    logic          tick;
    logic          handshake;

    assign tick      = (state_q != StIdle) && (div_q == LastDiv);
    assign handshake = valid_q && sample_ready;

    assign rom_addr     = {30'(idx_q), 2'b00};
    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != StIdle);
    assign done         = done_q;
    assign underrun     = underrun_q;

    // Next-state logic: playback FSM, rate divider, pending-tick bookkeeping and pulses.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tick_pend_d = tick_pend_q;
        data_d      = data_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
        underrun_d  = 1'b0;
        div_d       = (state_q == StIdle || tick) ? '0 : div_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    idx_d   = '0;
                    div_d   = '0;
                end
            end
            StFetch: begin
                tick_pend_d = 1'b0;
                state_d     = StCapture;
            end
            StCapture: begin
                data_d  = rom_rd;
                valid_d = 1'b1;
                state_d = StPresent;
            end
            StPresent: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    if (idx_q == LastIdx) begin
`ifdef AUDIO_STREAM_LOOP_EN
                        idx_d   = '0;
                        state_d = StPace;
`else
                        done_d  = 1'b1;
                        idx_d   = '0;
                        state_d = StIdle;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StPace;
                    end
                end
            end
            StPace: begin
                if (tick || tick_pend_q) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase

        // A tick that lands while a sample is still in flight is remembered, not dropped.
        if (tick && (state_q inside {StFetch, StCapture, StPresent})) begin
            tick_pend_d = 1'b1;
            underrun_d  = 1'b1;
        end

        // Abort overrides everything, including a same-cycle start or final handshake.
        if (stop) begin
            state_d     = StIdle;
            valid_d     = 1'b0;
            idx_d       = '0;
            div_d       = '0;
            tick_pend_d = 1'b0;
            done_d      = 1'b0;
            underrun_d  = 1'b0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            div_q       <= '0;
            tick_pend_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            div_q       <= div_d;
            tick_pend_q <= tick_pend_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule

// File: tb/tb_audio_sample_streamer.sv
// Bench for audio_sample_streamer: random ROM image and random consumer stalls, checked
// against a timing model where fetches sit on a SAMPLE_DIV grid measured from start, and a
// grid tick missed while a sample is outstanding triggers an immediate fetch after accept.
module tb_audio_sample_streamer;

    localparam int NUM = 12;
    localparam int DIV = 6;

    logic        clk = 1'b0;
    logic        rst, start, stop, sample_ready;
    logic [31:0] rom_addr;
    logic [15:0] rom_rd;
    logic [15:0] sample_data;
    logic        sample_valid, busy, done, underrun;

    logic [15:0] rom_mem [16];

    int cyc = 0;
    int done_cnt = 0;
    int ur_cnt = 0;
    int ur_base = 0;
    int total = 0;
    int bad = 0;
    int s_edge = 0;
    int fetch_edge = 0;

    audio_sample_streamer #(
        .NUM_SAMPLES(NUM),
        .SAMPLE_DIV (DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .rom_addr    (rom_addr),
        .rom_rd      (rom_rd),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .busy        (busy),
        .done        (done),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    // ROM with a 1-cycle registered read.
    always @(posedge clk) rom_rd <= rom_mem[rom_addr[5:2]];

    // Edge counter and pulse counters (a pulse after edge g is counted at edge g+1).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (underrun === 1'b1) ur_cnt <= ur_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse start; the sampling edge becomes the origin of the pacing grid.
    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        s_edge     = cyc;
        fetch_edge = cyc;
        ur_base    = ur_cnt;
        @(negedge clk);
    endtask

    task automatic wait_valid(input int idx);
        int v;
        v = -1;
        for (int k = 0; k < 4 * DIV + 8; k++) begin
            if (sample_valid === 1'b1) begin
                v = cyc;
                break;
            end
            @(negedge clk);
        end
        check("valid_time", v, fetch_edge + 2);
        check("data", 32'(sample_data), 32'(rom_mem[idx]));
        check("rom_addr", rom_addr, idx * 4);
    endtask

    task automatic accept(input int idx, input int hold);
        int hs;
        int missed;
        int dn0;
        logic [15:0] held;
        dn0  = done_cnt;
        held = sample_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(sample_valid), 1);
            check("hold_data", 32'(sample_data), 32'(held));
        end
        sample_ready = 1'b1;
        @(posedge clk);
        #1;
        sample_ready = 1'b0;
        hs = cyc;
        missed = 0;
        for (int g = fetch_edge + 1; g <= hs; g++) begin
            if ((g - s_edge) % DIV == 0) missed++;
        end
        @(negedge clk);
        check("valid_drop", 32'(sample_valid), 0);
        @(negedge clk);
        check("underrun_cnt", ur_cnt - ur_base, missed);
        ur_base = ur_cnt;
`ifdef AUDIO_STREAM_LOOP_EN
        check("no_done", done_cnt - dn0, 0);
`else
        if (idx == NUM - 1) begin
            check("done_pulse", done_cnt - dn0, 1);
            check("busy_end", 32'(busy), 0);
        end else begin
            check("no_done", done_cnt - dn0, 0);
        end
`endif
        if (missed > 0) fetch_edge = hs + 1;
        else fetch_edge = hs + 1 + (DIV - (hs + 1 - s_edge) % DIV) % DIV;
    endtask

    task automatic play(input int idx, input int hold);
        wait_valid(idx);
        accept(idx, hold);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        @(negedge clk);
        check("stop_valid", 32'(sample_valid), 0);
        check("stop_busy", 32'(busy), 0);
        check("stop_addr", rom_addr, 0);
    endtask

    initial begin
        int dn_snap;
        int ur_snap;
        for (int i = 0; i < 16; i++) rom_mem[i] = 16'($urandom);
        rst          = 1'b1;
        start        = 1'b0;
        stop         = 1'b0;
        sample_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(sample_valid), 0);
        check("rst_addr", rom_addr, 0);
        check("rst_data", 32'(sample_data), 0);
        check("rst_done", 32'(done), 0);
        check("rst_underrun", 32'(underrun), 0);

        // start and stop together while idle: stop wins
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        check("start_stop_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        check("start_stop_valid", 32'(sample_valid), 0);

        // full clip with random stalls, a start while busy and a long stall
        do_start();
        for (int i = 0; i < 5; i++) play(i, int'($urandom_range(0, 2)));
        play(5, 3);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_while_busy", 32'(busy), 1);
        @(negedge clk);
        play(6, 0);
        play(7, DIV + 2);
        for (int i = 8; i < NUM; i++) play(i, int'($urandom_range(0, 4)));
`ifdef AUDIO_STREAM_LOOP_EN
        check("loop_busy", 32'(busy), 1);
        play(0, 0);
        play(1, int'($urandom_range(0, 3)));
        do_stop();
`else
        repeat (2) @(negedge clk);
        check("idle_after_done", 32'(busy), 0);
        check("idle_addr", rom_addr, 0);
`endif

        // stop while sample 3 is presented, then replay from 0
        do_start();
        for (int i = 0; i < 3; i++) play(i, 0);
        wait_valid(3);
        dn_snap = done_cnt;
        do_stop();
        repeat (3) @(negedge clk);
        check("stop_no_done", done_cnt - dn_snap, 0);
        check("stop_stays_idle", 32'(busy), 0);

        do_start();
        play(0, 0);
        wait_valid(1);

        // reset in the middle of playback
        dn_snap = done_cnt;
        ur_snap = ur_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(sample_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_addr", rom_addr, 0);
        check("mid_rst_data", 32'(sample_data), 0);
        repeat (DIV + 2) @(negedge clk);
        check("mid_rst_no_done", done_cnt - dn_snap, 0);
        check("mid_rst_no_underrun", ur_cnt - ur_snap, 0);
        check("mid_rst_idle", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
